// File: rtl/fpu_issue_ctrl.sv
// Issue/flow controller for the pipelined FP add/sub: arbitration, per-stage enables, valid/source tracking.
// Optional FPU_ISSUE_RR_EN selects round-robin tie-breaking; default is fixed priority to req0.
module fpu_issue_ctrl #(
  parameter int STAGES = 4,
  parameter int OCC_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req1_valid,
  output logic              req1_ready,
  output logic              issue_sel,
  output logic [STAGES-1:0] stage_en,
  input  logic              flush,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_src,
  output logic [OCC_W-1:0]  occupancy,
  output logic              busy
);

  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES-1:0] s_q, s_d;
  logic              last_q, last_d;
  logic              grant;
  logic              accept;
  logic [OCC_W-1:0]  occ;

  always_comb begin
    grant = last_q;
    if (req0_valid && req1_valid) begin
`ifdef FPU_ISSUE_RR_EN
      grant = ~last_q;
`else
      grant = 1'b0;
`endif
    end else if (req0_valid) begin
      grant = 1'b0;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  // Enables collapse bubbles: a stage moves if it is empty or the stage above moves.
  always_comb begin
    stage_en = '0;
    if (!flush) begin
      stage_en[STAGES-1] = !v_q[STAGES-1] | res_ready;
      for (int k = STAGES-2; k >= 0; k--) begin
        stage_en[k] = !v_q[k] | stage_en[k+1];
      end
    end
  end

  assign issue_sel  = grant;
  assign req0_ready = (grant == 1'b0) & stage_en[0] & !flush;
  assign req1_ready = (grant == 1'b1) & stage_en[0] & !flush;
  assign accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);

  always_comb begin
    v_d    = v_q;
    s_d    = s_q;
    last_d = accept ? grant : last_q;
    if (flush) begin
      v_d = '0;
    end else begin
      if (stage_en[0]) begin
        v_d[0] = accept;
        s_d[0] = grant;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (stage_en[k]) begin
          v_d[k] = v_q[k-1];
          s_d[k] = s_q[k-1];
        end
      end
    end
  end

  // Reset leaves last=1 so the first tie goes to req0 in either arbitration mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q    <= '0;
      s_q    <= '0;
      last_q <= 1'b1;
    end else begin
      v_q    <= v_d;
      s_q    <= s_d;
      last_q <= last_d;
    end
  end

  always_comb begin
    occ = '0;
    for (int k = 0; k < STAGES; k++) begin
      occ = occ + OCC_W'(v_q[k]);
    end
  end

  assign occupancy = occ;
  assign busy      = |v_q;
  assign res_valid = v_q[STAGES-1] & !flush;
  assign res_src   = s_q[STAGES-1];

endmodule

// File: doc/fpu_issue_ctrl.md
# fpu_issue_ctrl

Issue and flow controller for the pipelined floating-point add/sub datapath. Arbitrates between two operand requesters, drives the per-stage enable of every inter-stage pipeline register, and tracks a valid bit and source ID per stage so the result leaves with a valid/ready handshake. Sits between the requesters and the stage-A operand mux, with its `stage_en` bus wired to the `en` input of each pipeline register.

## Interface
- `STAGES`, 4: number of pipeline register stages (≥2); stage 0 captures issued operands, stage STAGES-1 holds the result.
- `OCC_W`, 3: occupancy width; must satisfy 2^OCC_W > STAGES.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `req0_valid`  in  1  requester 0 has operands.
- `req0_ready`  out  1  requester 0 operands accepted this cycle.
- `req1_valid`  in  1  requester 1 has operands.
- `req1_ready`  out  1  requester 1 operands accepted this cycle.
- `issue_sel`  out  1  stage-A operand mux select: 0 = req0, 1 = req1.
- `stage_en`  out  STAGES  enable for pipeline register k; bit 0 is the first stage.
- `flush`  in  1  discard all in-flight operations.
- `res_valid`  out  1  last stage holds a valid result.
- `res_ready`  in  1  consumer takes the result.
- `res_src`  out  1  requester ID of the result in the last stage.
- `occupancy`  out  OCC_W  number of valid stages.
- `busy`  out  1  any stage is valid.

## Operation
- State per stage k: valid bit `v[k]` and source bit `s[k]`. Grant pointer `last`: the most recently granted requester.
- Stage enables are combinational, with bubble collapse:
  - `stage_en[STAGES-1] = !v[STAGES-1] | res_ready`.
  - `stage_en[k] = !v[k] | stage_en[k+1]`.
- On an enabled edge, stage k+1 loads `v[k]` and `s[k]`. Stage 0 loads `v = accept` and `s = issue_sel`.
- Arbitration:
  - Only one requester valid: that requester is granted.
  - Both valid: grant `!last` (see Configuration).
  - Neither valid: `issue_sel` holds `last`.
- Ready outputs: `reqN_ready = grant==N & stage_en[0] & !flush`. Define `accept = req0_valid&req0_ready | req1_valid&req1_ready`. `last` updates only on accept.
- Result handshake: `res_valid = v[STAGES-1] & !flush` and `res_src = s[STAGES-1]`. The result retires when `res_valid & res_ready`.
- Flush:
  - During the flush cycle, all `stage_en` are 0 and both readies are 0.
  - At the next edge, every `v` clears. `s` and `last` hold.
- Counters: `occupancy` is the popcount of `v`. `busy = |v`.

## Timing
- Reset: `v`=0, `s`=0, `last`=1 (req0 wins the first tie).
- Outputs in reset (combinational from empty state): `res_valid`=0, `res_src`=0, `occupancy`=0, `busy`=0, `stage_en`=all ones. Readies follow requests, gated by `!flush`.
- Latency: an operation accepted in cycle 0 gives `res_valid` in cycle STAGES, provided there is no stall.
- Throughput: 1 operation per cycle while `res_ready` stays high.
- Full stall: all stages valid and `res_ready`=0 gives `stage_en`=0 and both readies 0. Data is held without loss or duplication.
- Partial stall: the lowest invalid stage and every stage below it still advance, so bubbles fill while the head is blocked.
- Simultaneous events:
  - Flush together with a request: flush wins and nothing is accepted.
  - Flush together with a valid head: `res_valid` is forced 0, so no retire.
  - Retire and accept in the same cycle: occupancy is unchanged.
- Reset asserted mid-operation clears all state immediately and asynchronously. The first accept after deassertion follows normal rules.
- `res_valid` must not deassert without a retire, except on flush or reset.

## Configuration
- `FPU_ISSUE_RR_EN` defined: round-robin on ties; the requester not granted last wins.
- Not defined: fixed priority, where req0 always wins a tie. `last` is still tracked for `issue_sel` idle hold.

## Test plan
- Reset, then req0_valid=1 for one cycle with res_ready=1 → req0_ready=1 in cycle 0; res_valid=1, res_src=0 in cycle 4 for exactly one cycle; occupancy 1,1,1,1,0.
- Both requesters valid continuously, res_ready=1, macro defined → grants 0,1,0,1,…; res_src the same sequence delayed 4 cycles. Macro undefined → all grants and res_src 0; req1_ready stays 0.
- Fill the pipe with res_ready=0 → occupancy reaches 4, stage_en=4'b0000, both readies 0. Raise res_ready → four consecutive retires in issue order.
- Head stalled, only v[3] set, req1 streaming → accepts on 3 consecutive cycles, occupancy 1→4, then ready drops to 0.
- Occupancy 3 with flush=1 and req0_valid=1 → req0_ready=0 and res_valid=0 that cycle; occupancy 0 next cycle; no stray res_valid afterwards.
- rst pulsed between edges with occupancy 2 → occupancy, busy and res_valid go to 0 immediately; the next tie is granted to req0.
